// File: rtl/adc_pkg.sv
// adc_pkg: shared frame geometry and sequencer state encoding for the SPI ADC scanner.
package adc_pkg;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_ADDR_W = 3;
  localparam int ADC_FIRST_DATA_BIT = 4;
  localparam int ADC_ADDR_BIT_K0 = 2;
  typedef enum logic [1:0] {IDLE, SETUP, FRAME, GAP} state_e;
endpackage

// File: rtl/adc_spi_frame.sv
// adc_spi_frame: runs one 16-period SPI frame: SCLK divider, bit counter, address drive, data shift.
module adc_spi_frame import adc_pkg::*; #(
  parameter int DATA_W = 12,
  parameter int SCLK_DIV = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADC_ADDR_W-1:0] addr_i,
  input  logic                  sdat_i,
  output logic                  sclk_o,
  output logic                  saddr_o,
  output logic                  done_o,
  output logic [DATA_W-1:0]     data_o
);
  localparam int DW = $clog2(SCLK_DIV);
  logic active_q, half_q, half_end;
  logic [DW-1:0] div_q;
  logic [3:0] k_q, kk;
  logic [ADC_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sh_q;
  assign half_end = div_q == DW'(SCLK_DIV - 1);
  assign kk = k_q - 4'(ADC_ADDR_BIT_K0);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      active_q <= 1'b0;
      half_q <= 1'b0;
      div_q <= '0;
      k_q <= '0;
      addr_q <= '0;
      sh_q <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      half_q <= 1'b0;
      div_q <= '0;
      k_q <= '0;
      addr_q <= addr_i;
    end else if (active_q) begin
      div_q <= half_end ? '0 : div_q + 1'b1;
      if (half_end) begin
        half_q <= ~half_q;
        if (half_q) begin
          k_q <= k_q + 1'b1;
          active_q <= k_q != 4'(ADC_FRAME_BITS - 1);
        end
        // sample on the last cycle of the low half, just before SCLK rises
        if (!half_q && k_q >= 4'(ADC_FIRST_DATA_BIT)) sh_q <= {sh_q[DATA_W-2:0], sdat_i};
      end
    end
  assign sclk_o = !(active_q && !half_q);
  assign saddr_o = active_q && kk < 4'(ADC_ADDR_W) ? addr_q[2'(ADC_ADDR_W - 1) - kk[1:0]] : 1'b0;
  assign done_o = active_q && half_q && half_end && k_q == 4'(ADC_FRAME_BITS - 1);
  assign data_o = sh_q;
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin SPI ADC scan with address pipeline, per-channel averaging
// and coherent publish of the averaged array.
module adc_scan_sequencer import adc_pkg::*; #(
  parameter int NUM_CH = 7,
  parameter int DATA_W = 12,
  parameter int SCLK_DIV = 25,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     c50m,
  input  logic                     reset_n,
  input  logic                     enable,
  output logic                     ADC_CS_N,
  output logic                     ADC_SCLK,
  output logic                     ADC_SADDR,
  input  logic                     ADC_SDAT,
  output logic [NUM_CH*DATA_W-1:0] adc_data,
  output logic                     data_valid,
  output logic                     sample_valid,
  output logic [2:0]               sample_ch,
  output logic [DATA_W-1:0]        sample_raw,
  output logic                     busy
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CW = $clog2(2 * SCLK_DIV);
  localparam int RW = AVG_LOG2 + 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic start, done, pub, primed_q;
  logic [ADC_ADDR_W-1:0] next_q, prev_q;
  logic [DATA_W-1:0] frame_data;
  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [RW-1:0] round_q;
  logic [NUM_CH*DATA_W-1:0] adc_data_q;
  logic data_valid_q, sample_valid_q;
  logic [2:0] sample_ch_q;
  logic [DATA_W-1:0] sample_raw_q;
  adc_spi_frame #(.DATA_W(DATA_W), .SCLK_DIV(SCLK_DIV)) u_frame (
    .clk_i(c50m), .rst_ni(reset_n), .start_i(start), .addr_i(next_q), .sdat_i(ADC_SDAT),
    .sclk_o(ADC_SCLK), .saddr_o(ADC_SADDR), .done_o(done), .data_o(frame_data)
  );
  always_comb begin
    state_d = state_q;
    start = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = SETUP;
      SETUP: if (cnt_q == CW'(SCLK_DIV - 1)) begin
        start = 1'b1;
        state_d = FRAME;
      end
      FRAME: if (done) state_d = GAP;
      GAP: if (cnt_q == CW'(2 * SCLK_DIV - 1)) state_d = enable ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign pub = round_q == RW'(1 << AVG_LOG2);
  always_ff @(posedge c50m or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      primed_q <= 1'b0;
      next_q <= '0;
      prev_q <= '0;
      round_q <= '0;
      adc_data_q <= '0;
      data_valid_q <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q <= '0;
      sample_raw_q <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= state_d != state_q ? '0 : cnt_q + 1'b1;
      // data of the first frame after IDLE belongs to a stale address
      if (state_q == IDLE && enable) primed_q <= 1'b0;
      else if (done) primed_q <= 1'b1;
      if (done) begin
        prev_q <= next_q;
        next_q <= next_q == ADC_ADDR_W'(NUM_CH - 1) ? '0 : next_q + 1'b1;
      end
      sample_valid_q <= done && primed_q;
      if (done && primed_q) begin
        sample_ch_q <= prev_q;
        sample_raw_q <= frame_data;
      end
      data_valid_q <= pub;
      if (pub) round_q <= '0;
      else if (sample_valid_q && sample_ch_q == 3'(NUM_CH - 1)) round_q <= round_q + 1'b1;
      for (int c = 0; c < NUM_CH; c++)
        if (pub) begin
          adc_data_q[c*DATA_W +: DATA_W] <= DATA_W'(acc_q[c] >> AVG_LOG2);
          acc_q[c] <= '0;
        end else if (sample_valid_q && sample_ch_q == 3'(c)) acc_q[c] <= acc_q[c] + ACC_W'(sample_raw_q);
    end
  assign ADC_CS_N = !(state_q == SETUP || state_q == FRAME);
  assign busy = state_q != IDLE;
  assign adc_data = adc_data_q;
  assign data_valid = data_valid_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch = sample_ch_q;
  assign sample_raw = sample_raw_q;
endmodule
